scan_ctrl: RTL and testbench
============================

# scan_ctrl

Controller that sequences the 8-digit seven-segment scan datapath. It arbitrates 16-bit display writes from two requesters: the CPU memory-mapped IO path and a debug/switch source. It converts the granted binary value to five BCD digits with a sequential double-dabble engine, computes leading-zero blanking, and generates the digit-refresh schedule for the segment decoder/driver.

## Interface
Parameters:
- REFRESH_DIV, 200000: scan_clk cycles per digit slot; legal range 2..2^24-1.
- NUM_DIGITS, 5: active digits scanned, indices 0..NUM_DIGITS-1; legal range 1..5.

Ports:
- scan_clk  in  1  clock.
- scan_rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU write request; level, held until cpu_ack.
- cpu_wdata  in  16  CPU write value, unsigned; stable while cpu_req is high.
- dbg_req  in  1  debug write request; level, held until dbg_ack.
- dbg_wdata  in  16  debug write value, unsigned.
- disp_en  in  1  0 blanks every digit.
- cpu_ack  out  1  one-cycle grant pulse to CPU.
- dbg_ack  out  1  one-cycle grant pulse to debug.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when bcd_out updates.
- bcd_out  out  20  five BCD digits; [3:0] is units, [19:16] is ten-thousands.
- blank  out  5  per-digit blank flags.
- digit_idx  out  3  current scanned digit.
- digit_sel  out  8  one-hot digit select; bit digit_idx set.
- digit_bcd  out  4  bcd_out nibble for digit_idx.
- digit_blank  out  1  blank[digit_idx] OR ~disp_en.

## Operation
- FSM states: IDLE, CONV, LOAD.
- IDLE to CONV when any request is present:
  - Latch the granted wdata into a 16-bit shift register.
  - Clear the 20-bit BCD accumulator and the 4-bit iteration counter.
  - Pulse the matching ack.
- Arbitration:
  - Single requester: grant it.
  - Both requesting: grant the one not granted last (round-robin).
  - last_grant resets to DBG, so the CPU wins the first tie.
- CONV runs 16 iterations, one per cycle:
  - Every BCD nibble ≥5 gets +3.
  - Then shift {bcd, bin} left by 1.
  - After iteration 16 (counter = 15), go to LOAD.
- LOAD:
  - bcd_out <= accumulator.
  - Recompute blank.
  - Pulse done.
  - Go to IDLE.
- Requests arriving in CONV/LOAD are not acked. They are serviced on return to IDLE.
- Blank rule:
  - blank[k] = 1 iff k>0 and every nibble at index ≥k is zero.
  - blank[k] = 1 for k ≥ NUM_DIGITS.
  - blank[0] is always 0 (value 0 shows "0").
- Refresh:
  - 24-bit prescaler counts 0..REFRESH_DIV-1.
  - At wrap, digit_idx increments; NUM_DIGITS-1 wraps to 0.
  - Refresh runs independently of the FSM.
- Reset (asserted any time, including mid-CONV):
  - State goes to IDLE and any conversion in progress is discarded.
  - bcd_out=0, blank=5'b11110, digit_idx=0, digit_sel=8'h01, prescaler=0.
  - busy=0, cpu_ack=0, dbg_ack=0, done=0, last_grant=DBG.

## Timing
- All outputs are registered except digit_bcd and digit_blank (combinational from registers and disp_en).
- Cycle numbering: E0 is the edge where IDLE samples a request.
- Ack: high in the cycle after E0 (one cycle).
- busy: high from E0 until the LOAD-to-IDLE edge (17 cycles).
- Conversion: iterations on E1..E16, LOAD on E17.
- bcd_out, blank and done: valid after E17. done is low again after E18.
- Earliest next acceptance is E18, so throughput is one write per 18 cycles.
- A requester must deassert req in the cycle after its ack. A req still high at the next IDLE is treated as a new write.
- digit_idx and digit_sel change exactly every REFRESH_DIV cycles. The first change comes REFRESH_DIV cycles after reset release.
- A bcd_out update mid-slot takes effect on digit_bcd immediately. No slot restart.

## Test plan
- Single CPU write:
  - Stimulus: cpu_wdata=1234 (0x04D2).
  - Response: cpu_ack 1 cycle after E0; done after E17; bcd_out=20'h01234; blank=5'b10000.
- Extremes:
  - 0 → bcd_out=0, blank=5'b11110.
  - 65535 → bcd_out=20'h65535, blank=5'b00000.
  - 10000 → bcd_out=20'h10000, blank=5'b00000.
- Simultaneous requests out of reset:
  - Stimulus: cpu_wdata=7, dbg_wdata=9, both req high.
  - Response: CPU acked first, dbg acked at E18.
  - Final bcd_out=20'h00009 after two done pulses.
  - A second tie grants DBG... only if CPU was last granted; check alternation.
- Refresh with REFRESH_DIV=4, NUM_DIGITS=5:
  - digit_idx sequence 0,1,2,3,4,0 with 4 cycles per value; digit_sel matches one-hot.
  - disp_en=0 forces digit_blank=1.
- Reset mid-conversion:
  - Stimulus: assert scan_rst during CONV iteration 8 of a 4321 write.
  - Response: bcd_out=0, busy=0, no done pulse.
  - A subsequent write of 4321 yields bcd_out=20'h04321.
- Request during busy:
  - Stimulus: dbg_req rises at E5 of a CPU conversion.
  - Response: no dbg_ack before E18; dbg_ack high in the cycle after E18.

Source files
------------

// File: rtl/scan_ctrl.sv
// ---------------------------------------------------------------------------
// scan_ctrl
//
// Sequencing controller for the 8-digit seven-segment scan datapath.
//
// A 16-bit display write is accepted from one of two requesters: the CPU
// memory-mapped IO path or the debug/switch source. When both request at
// once, the grant alternates between them. The granted binary value goes
// through a sequential double-dabble engine, one bit per cycle. The
// resulting five BCD digits are loaded into bcd_out together with
// leading-zero blank flags. Independently of the conversion, a prescaler
// steps the scanned digit index so the segment decoder/driver can show one
// digit per refresh slot.
//
// Parameters
//   REFRESH_DIV  scan_clk cycles per digit slot (2 .. 2^24-1)
//   NUM_DIGITS   number of active digits scanned (1 .. 5)
//
// Ports
//   scan_clk     clock
//   scan_rst     asynchronous active-high reset
//   cpu_req      CPU write request, level, held until cpu_ack
//   cpu_wdata    CPU write value (unsigned)
//   dbg_req      debug write request, level, held until dbg_ack
//   dbg_wdata    debug write value (unsigned)
//   disp_en      0 blanks every digit
//   cpu_ack      one-cycle grant pulse to the CPU
//   dbg_ack      one-cycle grant pulse to debug
//   busy         conversion in progress
//   done         one-cycle pulse when bcd_out updates
//   bcd_out      five BCD digits, [3:0] units .. [19:16] ten-thousands
//   blank        per-digit leading-zero blank flags
//   digit_idx    currently scanned digit
//   digit_sel    one-hot digit select (bit digit_idx set)
//   digit_bcd    bcd_out nibble for digit_idx (combinational)
//   digit_blank  blank[digit_idx] OR ~disp_en (combinational)
// ---------------------------------------------------------------------------
module scan_ctrl #(
    parameter int REFRESH_DIV = 200000,
    parameter int NUM_DIGITS  = 5
) (
    input  logic        scan_clk,
    input  logic        scan_rst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_wdata,
    input  logic        dbg_req,
    input  logic [15:0] dbg_wdata,
    input  logic        disp_en,
    output logic        cpu_ack,
    output logic        dbg_ack,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd_out,
    output logic [4:0]  blank,
    output logic [2:0]  digit_idx,
    output logic [7:0]  digit_sel,
    output logic [3:0]  digit_bcd,
    output logic        digit_blank
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } grant_t;

    localparam logic [23:0] PRESCALE_MAX = 24'(REFRESH_DIV - 1);
    localparam logic [2:0]  LAST_DIGIT   = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]  LAST_ITER    = 4'd15;
    localparam logic [4:0]  BLANK_RESET  = 5'b11110;

    state_t      state_q, state_d;
    grant_t      lastGrant_q, lastGrant_d;
    logic [15:0] binShift_q, binShift_d;
    logic [19:0] bcdAcc_q, bcdAcc_d;
    logic [3:0]  iterCnt_q, iterCnt_d;
    logic        cpuAck_q, cpuAck_d;
    logic        dbgAck_q, dbgAck_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [19:0] bcdOut_q, bcdOut_d;
    logic [4:0]  blank_q, blank_d;

    logic [23:0] prescale_q, prescale_d;
    logic [2:0]  digitIdx_q, digitIdx_d;
    logic [7:0]  digitSel_q, digitSel_d;

    logic        grantCpu;
    logic        grantDbg;
    logic [19:0] bcdAdj;

    // Double-dabble correction step: every BCD nibble of 5 or more gets +3
    // so that the following left shift carries correctly into the next
    // decimal digit.
    function automatic logic [19:0] addThree(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        for (int n = 0; n < 5; n++) begin
            if (v[4*n +: 4] >= 4'd5) begin
                r[4*n +: 4] = v[4*n +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Leading-zero blanking. Walking down from the most significant digit,
    // a digit is blanked while every nibble at or above it is zero. Digit 0
    // is never blanked so a value of zero still shows "0". Digits beyond
    // the active count are always blanked.
    function automatic logic [4:0] calcBlank(input logic [19:0] v);
        logic [4:0] b;
        logic       zeroAbove;
        b         = 5'b00000;
        zeroAbove = 1'b1;
        for (int k = 4; k >= 1; k--) begin
            zeroAbove = zeroAbove & (v[4*k +: 4] == 4'd0);
            b[k]      = zeroAbove | (k >= NUM_DIGITS);
        end
        return b;
    endfunction

    // Round-robin arbitration. A lone requester always wins; on a tie the
    // requester that was not granted last wins. lastGrant resets to debug,
    // so the CPU wins the first tie after reset.
    always_comb begin
        grantCpu = cpu_req & (~dbg_req | (lastGrant_q == GNT_DBG));
        grantDbg = dbg_req & ~grantCpu;
    end

    // Controller next-state logic. IDLE latches the granted write and
    // pulses the ack, CONV runs one double-dabble iteration per cycle for
    // 16 cycles, and LOAD publishes the result. Requests arriving outside
    // IDLE are simply left pending until the FSM gets back there.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        binShift_d  = binShift_q;
        bcdAcc_d    = bcdAcc_q;
        iterCnt_d   = iterCnt_q;
        cpuAck_d    = 1'b0;
        dbgAck_d    = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bcdOut_d    = bcdOut_q;
        blank_d     = blank_q;
        bcdAdj      = addThree(bcdAcc_q);

        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    state_d     = CONV;
                    binShift_d  = grantCpu ? cpu_wdata : dbg_wdata;
                    bcdAcc_d    = 20'h00000;
                    iterCnt_d   = 4'd0;
                    cpuAck_d    = grantCpu;
                    dbgAck_d    = grantDbg;
                    lastGrant_d = grantCpu ? GNT_CPU : GNT_DBG;
                    busy_d      = 1'b1;
                end
            end

            CONV: begin
                {bcdAcc_d, binShift_d} = {bcdAdj[18:0], binShift_q, 1'b0};
                iterCnt_d              = iterCnt_q + 4'd1;
                if (iterCnt_q == LAST_ITER) begin
                    state_d = LOAD;
                end
            end

            LOAD: begin
                bcdOut_d = bcdAcc_q;
                blank_d  = calcBlank(bcdAcc_q);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Controller state register. Reset discards any conversion in flight
    // and restores the display to a single "0".
    always_ff @(posedge scan_clk or posedge scan_rst) begin
        if (scan_rst) begin
            state_q     <= IDLE;
            lastGrant_q <= GNT_DBG;
            binShift_q  <= 16'h0000;
            bcdAcc_q    <= 20'h00000;
            iterCnt_q   <= 4'd0;
            cpuAck_q    <= 1'b0;
            dbgAck_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bcdOut_q    <= 20'h00000;
            blank_q     <= BLANK_RESET;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            binShift_q  <= binShift_d;
            bcdAcc_q    <= bcdAcc_d;
            iterCnt_q   <= iterCnt_d;
            cpuAck_q    <= cpuAck_d;
            dbgAck_q    <= dbgAck_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bcdOut_q    <= bcdOut_d;
            blank_q     <= blank_d;
        end
    end

    // Refresh schedule. The prescaler counts 0..REFRESH_DIV-1 and the digit
    // index advances on each wrap, so every digit owns exactly REFRESH_DIV
    // cycles. The select is kept registered alongside the index so the
    // driver sees a glitch-free one-hot code.
    always_comb begin
        prescale_d = prescale_q + 24'd1;
        digitIdx_d = digitIdx_q;
        digitSel_d = digitSel_q;
        if (prescale_q == PRESCALE_MAX) begin
            prescale_d = 24'd0;
            digitIdx_d = (digitIdx_q == LAST_DIGIT) ? 3'd0 : digitIdx_q + 3'd1;
            digitSel_d = 8'h01 << digitIdx_d;
        end
    end

    // Refresh registers. They run regardless of the controller state.
    always_ff @(posedge scan_clk or posedge scan_rst) begin
        if (scan_rst) begin
            prescale_q <= 24'd0;
            digitIdx_q <= 3'd0;
            digitSel_q <= 8'h01;
        end else begin
            prescale_q <= prescale_d;
            digitIdx_q <= digitIdx_d;
            digitSel_q <= digitSel_d;
        end
    end

    // Digit mux toward the segment decoder. It is combinational so that a
    // new bcd_out shows up immediately within the current slot.
    always_comb begin
        case (digitIdx_q)
            3'd0: begin
                digit_bcd   = bcdOut_q[3:0];
                digit_blank = blank_q[0] | ~disp_en;
            end
            3'd1: begin
                digit_bcd   = bcdOut_q[7:4];
                digit_blank = blank_q[1] | ~disp_en;
            end
            3'd2: begin
                digit_bcd   = bcdOut_q[11:8];
                digit_blank = blank_q[2] | ~disp_en;
            end
            3'd3: begin
                digit_bcd   = bcdOut_q[15:12];
                digit_blank = blank_q[3] | ~disp_en;
            end
            3'd4: begin
                digit_bcd   = bcdOut_q[19:16];
                digit_blank = blank_q[4] | ~disp_en;
            end
            default: begin
                digit_bcd   = 4'h0;
                digit_blank = 1'b1;
            end
        endcase
    end

    assign cpu_ack   = cpuAck_q;
    assign dbg_ack   = dbgAck_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bcd_out   = bcdOut_q;
    assign blank     = blank_q;
    assign digit_idx = digitIdx_q;
    assign digit_sel = digitSel_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scan_ctrl
//
// Scoreboard bench for scan_ctrl. Stimulus tasks push the expected result
// of each write (and the expected grant order) into queues; a monitor pops
// and compares whenever the DUT pulses done or an ack. A second instance
// with three active digits shares the inputs and exercises forced blanking
// and a shorter refresh wrap.
// ---------------------------------------------------------------------------
module tb_scan_ctrl;

    typedef struct {
        logic [19:0] bcd;
        logic [4:0]  blank5;
        logic [4:0]  blank3;
    } exp_t;

    logic        scan_clk = 1'b0;
    logic        scan_rst;
    logic        cpu_req;
    logic [15:0] cpu_wdata;
    logic        dbg_req;
    logic [15:0] dbg_wdata;
    logic        disp_en;

    logic        cpu_ack, dbg_ack, busy, done;
    logic [19:0] bcd_out;
    logic [4:0]  blank;
    logic [2:0]  digit_idx;
    logic [7:0]  digit_sel;
    logic [3:0]  digit_bcd;
    logic        digit_blank;

    logic        u3CpuAck, u3DbgAck, u3Busy, u3Done;
    logic [19:0] u3Bcd;
    logic [4:0]  u3Blank;
    logic [2:0]  u3Idx;
    logic [7:0]  u3Sel;
    logic [3:0]  u3DigitBcd;
    logic        u3DigitBlank;

    exp_t expQ[$];
    bit   ackQ[$];

    int compared   = 0;
    int mismatched = 0;

    // Main instance: fast refresh, all five digits active.
    scan_ctrl #(.REFRESH_DIV(4), .NUM_DIGITS(5)) dut (
        .scan_clk(scan_clk), .scan_rst(scan_rst),
        .cpu_req(cpu_req), .cpu_wdata(cpu_wdata),
        .dbg_req(dbg_req), .dbg_wdata(dbg_wdata),
        .disp_en(disp_en),
        .cpu_ack(cpu_ack), .dbg_ack(dbg_ack), .busy(busy), .done(done),
        .bcd_out(bcd_out), .blank(blank),
        .digit_idx(digit_idx), .digit_sel(digit_sel),
        .digit_bcd(digit_bcd), .digit_blank(digit_blank)
    );

    // Secondary instance: three active digits, slot of three cycles.
    scan_ctrl #(.REFRESH_DIV(3), .NUM_DIGITS(3)) dut3 (
        .scan_clk(scan_clk), .scan_rst(scan_rst),
        .cpu_req(cpu_req), .cpu_wdata(cpu_wdata),
        .dbg_req(dbg_req), .dbg_wdata(dbg_wdata),
        .disp_en(disp_en),
        .cpu_ack(u3CpuAck), .dbg_ack(u3DbgAck), .busy(u3Busy), .done(u3Done),
        .bcd_out(u3Bcd), .blank(u3Blank),
        .digit_idx(u3Idx), .digit_sel(u3Sel),
        .digit_bcd(u3DigitBcd), .digit_blank(u3DigitBlank)
    );

    always #5 scan_clk = ~scan_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flagFailure(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got timeout/unexpected event expected none at %0t", name, $time);
    endtask

    // Monitor: compares each done pulse and each ack against the queues.
    always @(negedge scan_clk) begin
        if (!scan_rst) begin
            if (done) begin
                if (expQ.size() == 0) begin
                    flagFailure("unexpected done");
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("bcd_out", 32'(bcd_out), 32'(e.bcd));
                    checkOutput("blank", 32'(blank), 32'(e.blank5));
                    checkOutput("u3 bcd_out", 32'(u3Bcd), 32'(e.bcd));
                    checkOutput("u3 blank", 32'(u3Blank), 32'(e.blank3));
                end
            end
            if (cpu_ack || dbg_ack) begin
                if (ackQ.size() == 0) begin
                    flagFailure("unexpected ack");
                end else begin
                    bit isDbg;
                    isDbg = ackQ.pop_front();
                    checkOutput("ack grant", 32'({dbg_ack, cpu_ack}), isDbg ? 32'd2 : 32'd1);
                end
            end
        end
    end

    task automatic waitDrain();
        int n = 0;
        while ((expQ.size() != 0 || ackQ.size() != 0) && n < 100) begin
            @(negedge scan_clk);
            n++;
        end
        if (expQ.size() != 0 || ackQ.size() != 0) begin
            flagFailure("scoreboard drain");
            expQ.delete();
            ackQ.delete();
        end
    endtask

    task automatic waitAck(output int n);
        n = 0;
        do begin
            @(negedge scan_clk);
            n++;
        end while (!(cpu_ack || dbg_ack) && n < 40);
        if (!(cpu_ack || dbg_ack)) flagFailure("ack timeout");
    endtask

    task automatic pushExp(input logic [19:0] bcd, input logic [4:0] b5, input logic [4:0] b3);
        exp_t e;
        e.bcd    = bcd;
        e.blank5 = b5;
        e.blank3 = b3;
        expQ.push_back(e);
    endtask

    // Single write from one requester, then wait for its result.
    task automatic applyStimulus(input bit isDbg, input logic [15:0] val,
                                 input logic [19:0] expBcd, input logic [4:0] b5,
                                 input logic [4:0] b3);
        int n;
        pushExp(expBcd, b5, b3);
        ackQ.push_back(isDbg);
        @(negedge scan_clk);
        if (isDbg) begin dbg_req = 1'b1; dbg_wdata = val; end
        else       begin cpu_req = 1'b1; cpu_wdata = val; end
        waitAck(n);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        waitDrain();
    endtask

    // Both requesters at once; the second grant must follow 18 cycles later.
    task automatic tieWrite(input bit dbgFirst,
                            input logic [15:0] cpuVal, input logic [19:0] cpuBcd,
                            input logic [4:0] cpuB5, input logic [4:0] cpuB3,
                            input logic [15:0] dbgVal, input logic [19:0] dbgBcd,
                            input logic [4:0] dbgB5, input logic [4:0] dbgB3);
        int n;
        if (dbgFirst) begin
            pushExp(dbgBcd, dbgB5, dbgB3); pushExp(cpuBcd, cpuB5, cpuB3);
        end else begin
            pushExp(cpuBcd, cpuB5, cpuB3); pushExp(dbgBcd, dbgB5, dbgB3);
        end
        ackQ.push_back(dbgFirst);
        ackQ.push_back(!dbgFirst);
        @(negedge scan_clk);
        cpu_req = 1'b1; cpu_wdata = cpuVal;
        dbg_req = 1'b1; dbg_wdata = dbgVal;
        waitAck(n);
        if (dbg_ack) dbg_req = 1'b0;
        else         cpu_req = 1'b0;
        waitAck(n);
        checkOutput("second grant latency", 32'(n), 32'd18);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        waitDrain();
    endtask

    // Refresh sequence, started on the negedge where reset is released.
    task automatic checkRefresh();
        for (int k = 1; k <= 24; k++) begin
            @(negedge scan_clk);
            checkOutput("digit_idx", 32'(digit_idx), 32'((k / 4) % 5));
            checkOutput("digit_sel", 32'(digit_sel), 32'(1 << ((k / 4) % 5)));
            checkOutput("u3 digit_idx", 32'(u3Idx), 32'((k / 3) % 3));
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst bcd_out", 32'(bcd_out), 32'h0);
        checkOutput("rst blank", 32'(blank), 32'b11110);
        checkOutput("rst digit_idx", 32'(digit_idx), 32'd0);
        checkOutput("rst digit_sel", 32'(digit_sel), 32'h01);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst acks", 32'({cpu_ack, dbg_ack}), 32'd0);
        checkOutput("rst u3 blank", 32'(u3Blank), 32'b11110);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [19:0] model;
        logic [4:0]  modelBlank;

        scan_rst  = 1'b1;
        cpu_req   = 1'b0;
        dbg_req   = 1'b0;
        cpu_wdata = 16'h0;
        dbg_wdata = 16'h0;
        disp_en   = 1'b1;
        repeat (3) @(negedge scan_clk);
        checkResetState();
        scan_rst = 1'b0;
        checkRefresh();

        // Single CPU write 1234 with explicit ack/done timing.
        pushExp(20'h01234, 5'b10000, 5'b11000);
        ackQ.push_back(1'b0);
        @(negedge scan_clk);
        cpu_req = 1'b1; cpu_wdata = 16'd1234;
        @(negedge scan_clk);
        checkOutput("cpu_ack after E0", 32'(cpu_ack), 32'd1);
        checkOutput("busy after E0", 32'(busy), 32'd1);
        cpu_req = 1'b0;
        n = 0;
        do begin
            @(negedge scan_clk);
            n++;
        end while (!done && n < 40);
        checkOutput("done latency", 32'(n), 32'd17);
        checkOutput("busy at done", 32'(busy), 32'd0);
        @(negedge scan_clk);
        checkOutput("done width", 32'(done), 32'd0);
        waitDrain();

        // Digit mux against the loaded 01234 with blank 10000.
        model      = 20'h01234;
        modelBlank = 5'b10000;
        for (int k = 0; k < 20; k++) begin
            int idx;
            @(negedge scan_clk);
            idx = int'(digit_idx);
            if (idx > 4) begin
                checkOutput("digit_idx range", 32'(idx), 32'd4);
            end else begin
                checkOutput("digit_bcd", 32'(digit_bcd), 32'(model[idx*4 +: 4]));
                checkOutput("digit_blank", 32'(digit_blank), 32'(modelBlank[idx]));
            end
        end
        disp_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge scan_clk);
            checkOutput("digit_blank disp_en=0", 32'(digit_blank), 32'd1);
        end
        disp_en = 1'b1;

        // Extremes.
        applyStimulus(1'b0, 16'd0,     20'h00000, 5'b11110, 5'b11110);
        applyStimulus(1'b1, 16'd65535, 20'h65535, 5'b00000, 5'b11000);
        applyStimulus(1'b0, 16'd10000, 20'h10000, 5'b00000, 5'b11000);

        // Tie out of reset: CPU first, then debug.
        @(negedge scan_clk);
        scan_rst = 1'b1;
        repeat (2) @(negedge scan_clk);
        scan_rst = 1'b0;
        tieWrite(1'b0, 16'd7, 20'h00007, 5'b11110, 5'b11110,
                       16'd9, 20'h00009, 5'b11110, 5'b11110);
        checkOutput("final bcd after tie", 32'(bcd_out), 32'h00009);

        // Alternation: after a lone CPU write, debug wins the next tie, and
        // since the CPU is then granted last, debug wins again.
        applyStimulus(1'b0, 16'd42, 20'h00042, 5'b11100, 5'b11100);
        tieWrite(1'b1, 16'd100, 20'h00100, 5'b11000, 5'b11000,
                       16'd200, 20'h00200, 5'b11000, 5'b11000);
        tieWrite(1'b1, 16'd3, 20'h00003, 5'b11110, 5'b11110,
                       16'd5, 20'h00005, 5'b11110, 5'b11110);

        // Reset during iteration 8 of a 4321 write.
        ackQ.push_back(1'b0);
        @(negedge scan_clk);
        cpu_req = 1'b1; cpu_wdata = 16'd4321;
        waitAck(n);
        cpu_req = 1'b0;
        repeat (7) @(negedge scan_clk);
        scan_rst = 1'b1;
        @(negedge scan_clk);
        checkResetState();
        @(negedge scan_clk);
        scan_rst = 1'b0;
        checkRefresh();
        applyStimulus(1'b0, 16'd4321, 20'h04321, 5'b10000, 5'b11000);

        // Debug request raised while a CPU conversion is busy.
        pushExp(20'h00500, 5'b11000, 5'b11000);
        pushExp(20'h00077, 5'b11100, 5'b11100);
        ackQ.push_back(1'b0);
        ackQ.push_back(1'b1);
        @(negedge scan_clk);
        cpu_req = 1'b1; cpu_wdata = 16'd500;
        waitAck(n);
        cpu_req = 1'b0;
        repeat (4) @(negedge scan_clk);
        dbg_req = 1'b1; dbg_wdata = 16'd77;
        n = 4;
        do begin
            @(negedge scan_clk);
            n++;
        end while (!dbg_ack && n < 40);
        checkOutput("dbg_ack after busy", 32'(n), 32'd18);
        dbg_req = 1'b0;
        waitDrain();

        repeat (3) @(negedge scan_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
